fft_output_serializer: RTL

// - Output unloader for the 32-point FFT: captures all 32 complex bins from the final stage in one

---
 rtl/fft_output_serializer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fft_output_serializer.sv
// Frame-to-stream unloader for the 32-point FFT: captures every bin in one handshake and emits one bin per beat.
// Build option: define FFT_SER_BITREV_EN to emit bins in natural order from a bit-reversed frame.
module fft_output_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int N_POINTS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_POINTS*DATA_WIDTH-1:0] in_real,
  input  logic [N_POINTS*DATA_WIDTH-1:0] in_imag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_real,
  output logic [DATA_WIDTH-1:0]          out_imag,
  output logic [ADDR_WIDTH-1:0]          out_index,
  output logic                           out_last
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_POINTS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  logic [0:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,       cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q,  out_last_d;
  logic [DATA_WIDTH-1:0] out_real_q,  out_real_d;
  logic [DATA_WIDTH-1:0] out_imag_q,  out_imag_d;

  logic [DATA_WIDTH-1:0] real_buf_q [N_POINTS];
  logic [DATA_WIDTH-1:0] imag_buf_q [N_POINTS];

  logic                  beat_done;
  logic                  load;
  logic [ADDR_WIDTH-1:0] rd_bin;

  assign beat_done = out_valid_q && out_ready;
  assign in_ready  = (state_q == ST_IDLE) || (beat_done && out_last_q);
  assign load      = in_valid && in_ready;

`ifdef FFT_SER_BITREV_EN
  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
    for (int b = 0; b < ADDR_WIDTH; b++) begin
      bitrev[b] = a[ADDR_WIDTH-1-b];
    end
  endfunction

  assign rd_bin = bitrev(cnt_q + ONE);
`else
  assign rd_bin = cnt_q + ONE;
`endif

  // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;

    if (load) begin
      // Beat 0 reads bin 0 in both orderings (bitrev(0) == 0), so it comes straight off the input bus.
      state_d     = ST_STREAM;
      cnt_d       = '0;
      out_valid_d = 1'b1;
      out_last_d  = (LAST_IDX == '0);
      out_real_d  = in_real[DATA_WIDTH-1:0];
      out_imag_d  = in_imag[DATA_WIDTH-1:0];
    end else if (beat_done) begin
      if (out_last_q) begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        cnt_d       = cnt_q + ONE;
        out_last_d  = (cnt_d == LAST_IDX);
        out_real_d  = real_buf_q[rd_bin];
        out_imag_d  = imag_buf_q[rd_bin];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
    end
  end

  // NOTE: the capture buffer is cleared on reset so a stale frame can never leak after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_POINTS; k++) begin
        real_buf_q[k] <= '0;
        imag_buf_q[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < N_POINTS; k++) begin
        real_buf_q[k] <= in_real[k*DATA_WIDTH +: DATA_WIDTH];
        imag_buf_q[k] <= in_imag[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_index = cnt_q;

endmodule
